// File: rtl/reservoir_input_masker.sv
// Time-multiplexes each input sample across VIRTUAL_NODES virtual nodes by
// multiplying it with a per-node signed mask and streaming one value per clock.
module reservoir_input_masker #(
    parameter int VIRTUAL_NODES  = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 16,
    parameter int MASK_FRAC_BITS = 14,
    parameter int NODE_IDX_WIDTH = $clog2(VIRTUAL_NODES)
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESETN,
    input  logic                             en,
    input  logic                             mask_wen,
    input  logic        [NODE_IDX_WIDTH-1:0] mask_waddr,
    input  logic signed [MASK_WIDTH-1:0]     mask_wdata,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    input  logic signed [DATA_WIDTH-1:0]     sample_data,
    output logic signed [DATA_WIDTH-1:0]     dout,
    output logic                             dout_valid,
    output logic        [NODE_IDX_WIDTH-1:0] node_idx,
    output logic                             sample_done,
    output logic                             busy
);

    localparam int PROD_WIDTH = DATA_WIDTH + MASK_WIDTH;
    localparam logic [NODE_IDX_WIDTH-1:0] LAST_NODE = NODE_IDX_WIDTH'(VIRTUAL_NODES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic    [NODE_IDX_WIDTH-1:0] cnt;
    logic    [NODE_IDX_WIDTH-1:0] cnt_next;
    logic                         load_sample;
    logic                         issue_p0;
    logic                         accept;
    logic                         mask_accept;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic signed [MASK_WIDTH-1:0] mask_mem [VIRTUAL_NODES];
    logic signed [MASK_WIDTH-1:0] mask_p0;
    logic signed [PROD_WIDTH-1:0] prod_p0;

    logic                         vld_p1;
    logic signed [PROD_WIDTH-1:0] prod_p1;
    logic    [NODE_IDX_WIDTH-1:0] idx_p1;

    logic                         vld_p2;
    logic                         done_p2;

    // Floor division by 2^MASK_FRAC_BITS (arithmetic shift rounds toward -inf).
    function automatic logic signed [PROD_WIDTH-1:0] floor_shift(
        input logic signed [PROD_WIDTH-1:0] p
    );
        return p >>> MASK_FRAC_BITS;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [PROD_WIDTH-1:0] v
    );
        logic [PROD_WIDTH-DATA_WIDTH:0] hi;
        hi = v[PROD_WIDTH-1:DATA_WIDTH-1];
        if ((&hi) || (~|hi)) begin
            return v[DATA_WIDTH-1:0];
        end else if (v[PROD_WIDTH-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    // Ready in IDLE, or on the last-node cycle of RUN so samples can chain without a bubble.
    assign sample_ready = S_AXI_ARESETN && en &&
                          ((state == IDLE) || ((state == RUN) && (cnt == LAST_NODE)));
    assign accept       = sample_valid && sample_ready;
    assign busy         = accept || (state == RUN) || vld_p1 || vld_p2;
    assign mask_accept  = mask_wen && !busy && (mask_waddr <= LAST_NODE);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load_sample = 1'b0;
        issue_p0    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = RUN;
                    cnt_next    = '0;
                    load_sample = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    issue_p0 = 1'b1;
                    if (cnt == LAST_NODE) begin
                        if (accept) begin
                            cnt_next    = '0;
                            load_sample = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + NODE_IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (load_sample) begin
            sample_q <= sample_data;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < VIRTUAL_NODES; i++) begin
                mask_mem[i] <= '0;
            end
        end else if (mask_accept) begin
            mask_mem[mask_waddr] <= mask_wdata;
        end
    end

    // Stage 0: node issue, mask lookup and full-precision product
    assign mask_p0 = mask_mem[cnt];
    assign prod_p0 = $signed({{MASK_WIDTH{sample_q[DATA_WIDTH-1]}}, sample_q}) *
                     $signed({{DATA_WIDTH{mask_p0[MASK_WIDTH-1]}}, mask_p0});

    // Stage 1: registered product
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= issue_p0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (en && issue_p0) begin
            prod_p1 <= prod_p0;
            idx_p1  <= cnt;
        end
    end

    // Stage 2: scale, saturate and present; dout holds between valid beats
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            vld_p2   <= 1'b0;
            done_p2  <= 1'b0;
            dout     <= '0;
            node_idx <= '0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            done_p2 <= vld_p1 && (idx_p1 == LAST_NODE);
            if (vld_p1) begin
                dout     <= saturate(floor_shift(prod_p1));
                node_idx <= idx_p1;
            end
        end
    end

    // A beat held during a stall is presented once en returns.
    assign dout_valid  = vld_p2 && en;
    assign sample_done = done_p2 && en;

endmodule

// File: tb/tb_reservoir_input_masker.sv
// Directed bench for reservoir_input_masker with a queue-based scoreboard.
module tb_reservoir_input_masker;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mask_wen;
    logic [3:0]  mask_waddr;
    logic [15:0] mask_wdata;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] sample_data;
    logic [31:0] dout;
    logic        dout_valid;
    logic [3:0]  node_idx;
    logic        sample_done;
    logic        busy;

    always #5 clk = ~clk;

    reservoir_input_masker dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .en            (en),
        .mask_wen      (mask_wen),
        .mask_waddr    (mask_waddr),
        .mask_wdata    (mask_wdata),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_data   (sample_data),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .node_idx      (node_idx),
        .sample_done   (sample_done),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  idx;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nvalid = 0;
    logic [15:0] mmodel[N];

    function automatic logic [31:0] model_out(input logic [31:0] s, input logic [15:0] m);
        longint p;
        p = longint'($signed(s)) * longint'($signed(m));
        p = p >>> 14;
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (dout_valid) begin
            nvalid++;
            chk("unexpected_valid", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dout", dout, e.d);
                chk("node_idx", 32'(node_idx), 32'(e.idx));
                chk("sample_done", 32'(sample_done), 32'(e.done));
                if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
            end
        end else begin
            chk("done_without_valid", 32'(sample_done), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [31:0] s, input bit keep, input bit timed, output int waits);
        exp_t e;
        sample_valid = 1'b1;
        sample_data  = s;
        waits = 0;
        while (!sample_ready && waits < 50) begin
            tick();
            waits++;
        end
        chk("ready_timeout", 32'(sample_ready), 32'd1);
        tick();
        for (int i = 0; i < N; i++) begin
            e.d    = model_out(s, mmodel[i]);
            e.idx  = i[3:0];
            e.done = (i == N - 1);
            e.cyc  = timed ? cyc + 2 + i : -1;
            sb.push_back(e);
        end
        if (!keep) sample_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic wmask(input logic [3:0] addr, input logic [15:0] data, input bit upd);
        mask_wen   = 1'b1;
        mask_waddr = addr;
        mask_wdata = data;
        tick();
        mask_wen = 1'b0;
        if (upd) mmodel[addr] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        int          n0;
        logic [15:0] bm[N];
        bm = '{16'h4000, 16'hC000, 16'h2000, 16'h0000, 16'h4000,
               16'h4000, 16'hC000, 16'h2000, 16'h0000, 16'h4000};
        rst_n = 1'b0; en = 1'b1; mask_wen = 1'b0; mask_waddr = '0; mask_wdata = '0;
        sample_valid = 1'b0; sample_data = '0;
        for (int i = 0; i < N; i++) mmodel[i] = '0;

        @(posedge clk);
        #1;
        repeat (3) tick();
        chk("ready_in_reset", 32'(sample_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_dout", dout, 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_node_idx", 32'(node_idx), 32'd0);
        chk("rst_done", 32'(sample_done), 32'd0);

        // Unloaded masks give all-zero outputs.
        send(32'd5, 1'b0, 1'b1, w);
        drain(14);

        // Basic masking.
        for (int i = 0; i < N; i++) wmask(i[3:0], bm[i], 1'b1);
        send(32'd100, 1'b0, 1'b1, w);
        drain(14);
        chk("idle_busy", 32'(busy), 32'd0);

        // Back-to-back samples with sample_valid held.
        send(32'd7, 1'b1, 1'b1, w);
        send(32'd9, 1'b0, 1'b1, w);
        chk("b2b_ready_wait", w, 9);
        drain(14);

        // Saturation and floor rounding.
        wmask(4'd0, 16'h7FFF, 1'b1);
        send(32'h7FFF_FFFF, 1'b0, 1'b1, w);
        drain(14);
        send(32'h8000_0000, 1'b0, 1'b1, w);
        drain(14);
        wmask(4'd0, 16'h0001, 1'b1);
        send(32'hFFFF_FFFF, 1'b0, 1'b1, w);
        drain(14);

        // Stall for 4 cycles once node 3 has been presented.
        n0 = nvalid;
        send(32'd1000, 1'b0, 1'b0, w);
        repeat (6) tick();
        en = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", 32'(dout_valid), 32'd0);
            chk("stall_done", 32'(sample_done), 32'd0);
            chk("stall_ready", 32'(sample_ready), 32'd0);
            chk("stall_dout", dout, model_out(32'd1000, mmodel[4]));
            chk("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        en = 1'b1;
        drain(14);
        chk("stall_count", nvalid - n0, 10);

        // Writes while busy and out-of-range writes are dropped.
        send(32'd200, 1'b0, 1'b1, w);
        mask_wen = 1'b1; mask_waddr = 4'd2; mask_wdata = 16'h1000;
        tick();
        mask_wen = 1'b0;
        drain(14);
        wmask(4'd12, 16'h1234, 1'b0);
        send(32'd300, 1'b0, 1'b1, w);
        drain(14);

        // Reset while node 5 is on dout.
        send(32'd400, 1'b0, 1'b1, w);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        chk("ready_in_midreset", 32'(sample_ready), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_done", 32'(sample_done), 32'd0);
        chk("midrst_dout", dout, 32'd0);
        chk("midrst_ready", 32'(sample_ready), 32'd1);
        repeat (6) tick();
        for (int i = 0; i < N; i++) mmodel[i] = '0;
        send(32'd55, 1'b0, 1'b1, w);
        drain(14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
